// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle RV32 control FSM and its datapath.
interface multicycle_control_if;
   logic [31:0] inst;
   logic        zero;
   logic        PCWrite;
   logic        IorD;
   logic        MemRead;
   logic        MemWrite;
   logic        IRWrite;
   logic        MemtoReg;
   logic        RegWrite;
   logic        ALUSrcA;
   logic [1:0]  ALUSrcB;
   logic        PCSource;
   logic [3:0]  ALUControl;
   logic [3:0]  state;
   logic [31:0] retired;
   logic        illegal;

   modport master (
      input  inst, zero,
      output PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite,
             ALUSrcA, ALUSrcB, PCSource, ALUControl, state, retired, illegal
   );

   modport slave (
      output inst, zero,
      input  PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite,
             ALUSrcA, ALUSrcB, PCSource, ALUControl, state, retired, illegal
   );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RV32 datapath (Moore-decoded selects/enables).
// Optional MC_CTRL_ILLEGAL_HALT_EN: illegal opcodes park the FSM in HALT and set a sticky flag.
module multicycle_control (
   input  logic clk,
   input  logic reset,
   multicycle_control_if.master bus
);
   localparam int unsigned RET_W = 32;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEM_ADDR = 4'd2,
      MEM_RD   = 4'd3,
      MEM_WB   = 4'd4,
      MEM_WR   = 4'd5,
      EXEC     = 4'd6,
      ALU_WB   = 4'd7,
      BRANCH   = 4'd8
`ifdef MC_CTRL_ILLEGAL_HALT_EN
      , HALT   = 4'd9
`endif
   } state_e;

   state_e           state_q, state_d;
   logic [RET_W-1:0] retired_q, retired_d;
   logic             retire_c;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7_b5;
   logic       unused_inst;

   assign opcode      = bus.inst[6:0];
   assign funct3      = bus.inst[14:12];
   assign funct7_b5   = bus.inst[30];
   assign unused_inst = ^{bus.inst[31], bus.inst[29:15], bus.inst[11:7]};

   logic       pc_write, iord, mem_read, mem_write, ir_write;
   logic       mem_to_reg, reg_write, alu_src_a, pc_source;
   logic [1:0] alu_src_b;
   logic [3:0] alu_control;

`ifdef MC_CTRL_ILLEGAL_HALT_EN
   logic illegal_q, illegal_d;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= FETCH;
         retired_q <= '0;
`ifdef MC_CTRL_ILLEGAL_HALT_EN
         illegal_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         retired_q <= retired_d;
`ifdef MC_CTRL_ILLEGAL_HALT_EN
         illegal_q <= illegal_d;
`endif
      end
   end

   // Next-state, retire strobe and raw (ungated) control decode
   always_comb begin
      state_d     = state_q;
      retire_c    = 1'b0;
      pc_write    = 1'b0;
      iord        = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      mem_to_reg  = 1'b0;
      reg_write   = 1'b0;
      alu_src_a   = 1'b0;
      alu_src_b   = 2'b00;
      pc_source   = 1'b0;
      alu_control = ALU_AND;
`ifdef MC_CTRL_ILLEGAL_HALT_EN
      illegal_d   = illegal_q;
`endif
      case (state_q)
         FETCH: begin
            mem_read    = 1'b1;
            ir_write    = 1'b1;
            alu_src_b   = 2'b01;
            alu_control = ALU_ADD;
            pc_write    = 1'b1;
            state_d     = DECODE;
         end
         DECODE: begin
            alu_src_b   = 2'b10;
            alu_control = ALU_ADD;
            case (opcode)
               OP_LOAD, OP_STORE: state_d = MEM_ADDR;
               OP_RTYPE, OP_ITYPE: state_d = EXEC;
               OP_BRANCH:         state_d = BRANCH;
               default: begin
`ifdef MC_CTRL_ILLEGAL_HALT_EN
                  state_d   = HALT;
                  illegal_d = 1'b1;
`else
                  // PC already advanced in FETCH, so this retires as a NOP
                  state_d  = FETCH;
                  retire_c = 1'b1;
`endif
               end
            endcase
         end
         MEM_ADDR: begin
            alu_src_a   = 1'b1;
            alu_src_b   = 2'b10;
            alu_control = ALU_ADD;
            state_d     = (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
         end
         MEM_RD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
            state_d  = MEM_WB;
         end
         MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            state_d    = FETCH;
            retire_c   = 1'b1;
         end
         MEM_WR: begin
            mem_write = 1'b1;
            iord      = 1'b1;
            state_d   = FETCH;
            retire_c  = 1'b1;
         end
         EXEC: begin
            alu_src_a   = 1'b1;
            alu_control = ALU_ADD;
            if (opcode == OP_RTYPE) begin
               alu_src_b = 2'b00;
               case (funct3)
                  3'b000:  alu_control = funct7_b5 ? ALU_SUB : ALU_ADD;
                  3'b111:  alu_control = ALU_AND;
                  3'b110:  alu_control = ALU_OR;
                  default: alu_control = ALU_ADD;
               endcase
            end else begin
               alu_src_b = 2'b10;
            end
            state_d = ALU_WB;
         end
         ALU_WB: begin
            reg_write = 1'b1;
            state_d   = FETCH;
            retire_c  = 1'b1;
         end
         BRANCH: begin
            alu_src_a   = 1'b1;
            alu_control = ALU_SUB;
            pc_source   = 1'b1;
            pc_write    = bus.zero;
            state_d     = FETCH;
            retire_c    = 1'b1;
         end
`ifdef MC_CTRL_ILLEGAL_HALT_EN
         HALT: state_d = HALT;
`endif
         default: state_d = FETCH;
      endcase
      retired_d = retired_q + RET_W'(retire_c);
   end

   // Reset forces every control output low regardless of the state register
   assign bus.PCWrite    = pc_write   & ~reset;
   assign bus.IorD       = iord       & ~reset;
   assign bus.MemRead    = mem_read   & ~reset;
   assign bus.MemWrite   = mem_write  & ~reset;
   assign bus.IRWrite    = ir_write   & ~reset;
   assign bus.MemtoReg   = mem_to_reg & ~reset;
   assign bus.RegWrite   = reg_write  & ~reset;
   assign bus.ALUSrcA    = alu_src_a  & ~reset;
   assign bus.PCSource   = pc_source  & ~reset;
   assign bus.ALUSrcB    = reset ? 2'b00 : alu_src_b;
   assign bus.ALUControl = reset ? 4'b0000 : alu_control;
   assign bus.state      = reset ? 4'd0 : state_q;
   assign bus.retired    = retired_q;
`ifdef MC_CTRL_ILLEGAL_HALT_EN
   assign bus.illegal    = illegal_q;
`else
   assign bus.illegal    = 1'b0;
`endif
endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-instruction step tables feed a queue, a monitor checks every cycle.
module tb_multicycle_control;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   multicycle_control_if bus();
   multicycle_control dut (.clk(clk), .reset(reset), .bus(bus));

   typedef struct packed {
      logic [3:0]  st;
      logic [14:0] ctrl;
      logic [31:0] ret;
      logic        ill;
   } exp_t;

   localparam logic [3:0] A_AND = 4'b0000;
   localparam logic [3:0] A_OR  = 4'b0001;
   localparam logic [3:0] A_ADD = 4'b0010;
   localparam logic [3:0] A_SUB = 4'b0110;

   exp_t        exp_q[$];
   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   logic [31:0] m_retired;
   logic        m_illegal;
   logic        done;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
      end
   endtask

   // {PCWrite,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,PCSource,ALUControl}
   function automatic logic [14:0] mk(input logic pcw, iord, mr, mw, irw, m2r, rw, sa,
                                      input logic [1:0] sb, input logic pcs, input logic [3:0] alu);
      return {pcw, iord, mr, mw, irw, m2r, rw, sa, sb, pcs, alu};
   endfunction

   function automatic void push(input logic [3:0] st, input logic [14:0] ctrl);
      exp_q.push_back('{st: st, ctrl: ctrl, ret: m_retired, ill: m_illegal});
   endfunction

   function automatic logic [3:0] r_alu(input logic [31:0] ins);
      logic [2:0] f3;
      f3 = ins[14:12];
      if (f3 == 3'b000) return ins[30] ? A_SUB : A_ADD;
      if (f3 == 3'b111) return A_AND;
      if (f3 == 3'b110) return A_OR;
      return A_ADD;
   endfunction

   function automatic logic [3:0] ins_state(input int unsigned k);
      return 4'(k);
   endfunction

   task automatic wait_cycles(input int unsigned n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      exp_q.delete();
      m_retired = '0;
      m_illegal = 1'b0;
      wait_cycles(2);
      reset = 1'b0;
   endtask

   // Entered at one time unit after a rising edge, with the DUT in FETCH
   task automatic run_inst(input logic [31:0] ins, input logic z);
      logic [6:0]  op;
      int unsigned n;
      op = ins[6:0];
      bus.inst = ins;
      bus.zero = z;
      push(ins_state(0), mk(1, 0, 1, 0, 1, 0, 0, 0, 2'b01, 0, A_ADD));
      push(ins_state(1), mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 0, A_ADD));
      n = 2;
      if (op == 7'b0000011) begin
         push(ins_state(2), mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0, A_ADD));
         push(ins_state(3), mk(0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 0, A_AND));
         push(ins_state(4), mk(0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 0, A_AND));
         n = 5;
      end else if (op == 7'b0100011) begin
         push(ins_state(2), mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0, A_ADD));
         push(ins_state(5), mk(0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 0, A_AND));
         n = 4;
      end else if (op == 7'b0110011) begin
         push(ins_state(6), mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, r_alu(ins)));
         push(ins_state(7), mk(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 0, A_AND));
         n = 4;
      end else if (op == 7'b0010011) begin
         push(ins_state(6), mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0, A_ADD));
         push(ins_state(7), mk(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 0, A_AND));
         n = 4;
      end else if (op == 7'b1100011) begin
         push(ins_state(8), mk(z, 0, 0, 0, 0, 0, 0, 1, 2'b00, 1, A_SUB));
         n = 3;
      end else begin
`ifdef MC_CTRL_ILLEGAL_HALT_EN
         m_illegal = 1'b1;
         for (int i = 0; i < 4; i++) push(ins_state(9), '0);
         wait_cycles(6);
         check("illegal_sticky", 32'(bus.illegal), 32'd1);
         do_reset();
         return;
`endif
      end
      m_retired = m_retired + 32'd1;
      wait_cycles(n);
   endtask

   // Abort a load partway through with reset; retired must return to 0
   task automatic run_abort(input logic [31:0] ins);
      bus.inst = ins;
      push(ins_state(0), mk(1, 0, 1, 0, 1, 0, 0, 0, 2'b01, 0, A_ADD));
      push(ins_state(1), mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 0, A_ADD));
      push(ins_state(2), mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0, A_ADD));
      wait_cycles(3);
      do_reset();
   endtask

   function automatic logic [31:0] rand_inst();
      logic [31:0] ins;
      logic [6:0]  op;
      int unsigned k;
      ins = $urandom;
      k = $urandom_range(0, 5);
      case (k)
         0: op = 7'b0000011;
         1: op = 7'b0100011;
         2: op = 7'b0110011;
         3: op = 7'b0010011;
         4: op = 7'b1100011;
         default: begin
            op = 7'($urandom);
            while (op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 ||
                   op == 7'b0010011 || op == 7'b1100011)
               op = 7'($urandom);
         end
      endcase
      ins[6:0] = op;
      return ins;
   endfunction

   // Monitor: every cycle out of reset consumes one expected record
   initial begin
      logic prev_rst;
      exp_t e;
      logic [14:0] act;
      prev_rst = 1'b0;
      forever begin
         @(negedge clk);
         act = {bus.PCWrite, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite, bus.MemtoReg,
                bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.PCSource, bus.ALUControl};
         if (done) begin
            prev_rst = 1'b0;
         end else if (reset) begin
            check("reset_ctrl", 32'(act), 32'd0);
            check("reset_state", 32'(bus.state), 32'd0);
            if (prev_rst) begin
               check("reset_retired", bus.retired, 32'd0);
               check("reset_illegal", 32'(bus.illegal), 32'd0);
            end
            prev_rst = 1'b1;
         end else begin
            prev_rst = 1'b0;
            if (exp_q.size() == 0) begin
               check("scoreboard_underflow", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("state", 32'(bus.state), 32'(e.st));
               check("ctrl", 32'(act), 32'(e.ctrl));
               check("retired", bus.retired, e.ret);
               check("illegal", 32'(bus.illegal), 32'(e.ill));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      done      = 1'b0;
      reset     = 1'b1;
      bus.inst  = '0;
      bus.zero  = 1'b0;
      m_retired = '0;
      m_illegal = 1'b0;
      wait_cycles(3);
      reset = 1'b0;

      run_inst(32'h01400193, 1'b0); // addi x3,x0,20
      run_inst(32'h0781A403, 1'b0); // lw x8,120(x3)
      run_inst(32'h00818533, 1'b0); // add x10,x3,x8
      run_inst(32'h408505B3, 1'b0); // sub x11,x10,x8
      run_inst(32'h00B18463, 1'b1); // beq x3,x11,8 taken
      run_inst(32'h0081F6B3, 1'b0); // and x13,x3,x8
      run_inst(32'h0081E733, 1'b0); // or x14,x3,x8
      check("program_retired", bus.retired, 32'd7);
      run_inst(32'h00B18463, 1'b0); // beq not taken
      run_inst(32'h0000007F, 1'b0); // illegal opcode
      run_inst(32'h00802023, 1'b0); // sw
      run_abort(32'h0781A403);
      for (int i = 0; i < 300; i++)
         run_inst(rand_inst(), 1'($urandom));
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      done  = 1'b1;
      reset = 1'b1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle RV32 datapath. It decodes the instruction register output and drives every datapath select and enable, one instruction step per state: PC, IR, memory, register file, ALU and the muxes. Together with the datapath it forms a complete CPU.

## Interface
- No parameters.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- inst  in  32  current IR contents (opcode [6:0], funct3 [14:12], funct7 [31:25]).
- zero  in  1  ALU zero flag.
- PCWrite  out  1  PC load enable; already qualified by the branch result.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read enable.
- MemWrite  out  1  memory write enable.
- IRWrite  out  1  IR load enable.
- MemtoReg  out  1  register-write data select: 0 = ALUOut, 1 = MDR.
- RegWrite  out  1  register-file write enable.
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = A.
- ALUSrcB  out  2  ALU B select: 00 = B, 01 = 4, 10 = imm.
- PCSource  out  1  next-PC select: 0 = ALU result, 1 = ALUOut.
- ALUControl  out  4  ALU operation: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB.
- state  out  4  current state encoding, for debug.
- retired  out  32  count of completed instructions.
- illegal  out  1  sticky illegal-opcode flag.

## Operation
- State encodings: FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_RD = 3, MEM_WB = 4, MEM_WR = 5, EXEC = 6, ALU_WB = 7, BRANCH = 8, HALT = 9.
- Outputs are Moore-decoded from state. The one exception is PCWrite in BRANCH, which equals zero. Any output not listed for a state is 0.
- FETCH:
  - Drives MemRead=1, IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUControl=ADD, PCSource=0, PCWrite=1.
  - Next state is always DECODE.
- DECODE:
  - Drives ALUSrcA=0, ALUSrcB=10, ADD, so ALUOut = PC + imm. PC is already advanced here, so the branch target is branch_addr + 4 + imm.
  - Next state by opcode: 0000011 / 0100011 → MEM_ADDR; 0110011 / 0010011 → EXEC; 1100011 → BRANCH; any other opcode is illegal.
- MEM_ADDR:
  - Drives ALUSrcA=1, ALUSrcB=10, ADD.
  - Next state is MEM_RD for a load, MEM_WR for a store.
- MEM_RD: drives MemRead=1, IorD=1. Next state MEM_WB.
- MEM_WB: drives RegWrite=1, MemtoReg=1. Next state FETCH.
- MEM_WR: drives MemWrite=1, IorD=1. Next state FETCH.
- EXEC:
  - Drives ALUSrcA=1. ALUSrcB is 00 for R-type, 10 for 0010011.
  - ALUControl for R-type: funct3 000 with funct7[5]=0 → ADD; 000 with funct7[5]=1 → SUB; 111 → AND; 110 → OR; any other funct3 → ADD.
  - ALUControl for 0010011: always ADD.
  - Next state ALU_WB.
- ALU_WB: drives RegWrite=1, MemtoReg=0. Next state FETCH.
- BRANCH:
  - Drives ALUSrcA=1, ALUSrcB=00, SUB, PCSource=1, PCWrite=zero.
  - Next state FETCH.
- retired increments by 1 on each transition into FETCH from MEM_WB, MEM_WR, ALU_WB or BRANCH. It wraps modulo 2^32.
- An opcode that is X or Z in simulation is treated as illegal.

## Timing
- Reset:
  - Next state is FETCH; retired = 0, illegal = 0.
  - While reset is high, all control outputs are forced to 0. state reads 0.
  - Reset asserted in any state, including mid-instruction, aborts the instruction with no further writes.
- The first FETCH outputs appear in the first cycle after reset deasserts.
- Cycles per instruction: load 5, store 4, R-type 4, I-type ALU 4, beq 3.
- PCWrite, IRWrite, RegWrite and MemWrite are each high for exactly one cycle per state visit. Their effect lands at the next rising edge.
- A not-taken beq writes nothing; the PC keeps its FETCH-incremented value.

## Configuration
- MC_CTRL_ILLEGAL_HALT_EN, when defined:
  - An illegal opcode in DECODE goes to HALT and sets illegal=1.
  - HALT drives all outputs 0, does not increment retired, and is left only via reset.
- When undefined:
  - An illegal opcode in DECODE goes to FETCH, so the instruction acts as a NOP because the PC has already advanced.
  - retired still increments.
  - illegal is tied to 0 and the HALT state is not built.

## Test plan
- Reset, then release -> state=0 with FETCH outputs (PCWrite=1, IRWrite=1, ALUSrcB=01) in the first cycle; retired=0.
- addi x3,x0,20 at 0 -> states 0,1,6,7, then 0; RegWrite pulses in cycle 4; ALUSrcB=10 in EXEC; retired=1.
- lw x8,120(x3) with mem[140]=82 -> states 0,1,2,3,4; IorD=1 in MEM_RD; MemtoReg=1 with RegWrite in MEM_WB; x8=82.
- Run the program addi, lw, add, sub, beq x3,x11,8 from 0 -> x10=102, x11=20; beq taken with PCWrite=1 in BRANCH; next fetch at 28; and x13=16 and or x14=86 follow; retired=7 after 28 cycles.
- beq with unequal operands -> PCWrite=0 in BRANCH; next fetch at branch+4.
- Opcode 0x7F -> with MC_CTRL_ILLEGAL_HALT_EN: state=9, illegal=1, outputs 0 indefinitely, reset recovers; without it: back to FETCH, PC already advanced by 4, retired incremented, illegal stays 0.
